// File: rtl/conv_pkg.sv
// Shared constants, saturation helpers and FSM state type for the conv
// layer result path.
package conv_pkg;

  localparam int CONV_ACC_W  = 16;
  localparam int CONV_DATA_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // Clamp a CONV_ACC_W+1 bit signed sum into CONV_ACC_W bits.
  function automatic logic [CONV_ACC_W-1:0] sat_acc(input logic [CONV_ACC_W:0] v);
    logic [CONV_ACC_W-1:0] r;
    if (v[CONV_ACC_W] != v[CONV_ACC_W-1])
      r = v[CONV_ACC_W] ? {1'b1, {(CONV_ACC_W-1){1'b0}}} : {1'b0, {(CONV_ACC_W-1){1'b1}}};
    else
      r = v[CONV_ACC_W-1:0];
    return r;
  endfunction

  // Clamp a CONV_ACC_W+1 bit signed value into CONV_DATA_W bits.
  function automatic logic [CONV_DATA_W-1:0] sat_data(input logic [CONV_ACC_W:0] v);
    logic [CONV_ACC_W-CONV_DATA_W+1:0] upper;
    logic [CONV_DATA_W-1:0]            r;
    upper = v[CONV_ACC_W:CONV_DATA_W-1];
    if ((&upper) || !(|upper))
      r = v[CONV_DATA_W-1:0];
    else
      r = v[CONV_ACC_W] ? {1'b1, {(CONV_DATA_W-1){1'b0}}} : {1'b0, {(CONV_DATA_W-1){1'b1}}};
    return r;
  endfunction

endpackage

// File: rtl/acc_bank_ram.sv
// One accumulator bank: DEPTH x W storage, one write port and two
// registered read ports (accumulate path and readout path). Reads are
// read-first: a read and write to the same entry on one edge return the
// old contents. Maps onto a pair of simple dual-port block RAMs sharing
// the write port.
module acc_bank_ram #(
  parameter int DEPTH  = 784,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int W      = conv_pkg::CONV_ACC_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [W-1:0]      wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [W-1:0]      rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [W-1:0]      rdata_b
);

  logic [W-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read ports.
  always_ff @(posedge clk) begin
    rdata_a <= mem[raddr_a];
    rdata_b <= mem[raddr_b];
  end

endmodule

// File: rtl/result_acc_bank.sv
// Multi-channel accumulation buffer between the MAC array and the next
// layer's fetch. Two-stage read-modify-write with stage-2 forwarding,
// hardware clear sweep, per-channel bias and quantised readout.
// Build option: define RESULT_ACC_RELU_EN to clamp negative readouts to 0.
//
// Write handshake: a partial sum transfers on a rising clk edge where
// wr_valid && wr_ready; wr_ready depends only on the FSM state (high in
// IDLE), never on wr_valid. Out-of-range transfers are consumed and dropped.
module result_acc_bank
  import conv_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int DEPTH  = 784,
  parameter int DATA_W = CONV_DATA_W,
  parameter int ACC_W  = CONV_ACC_W,
  parameter int SHIFT  = 1,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_start,
  output logic              busy,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_first,
  input  logic              bias_we,
  input  logic [CH_W-1:0]   bias_ch,
  input  logic [DATA_W-1:0] bias_data,
  input  logic              rd_req,
  input  logic [CH_W-1:0]   rd_ch,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              err_oob
);

  state_t            state, next_state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              clr_last;
  logic              wr_oob, rd_oob, wr_fire, rd_fire;

  // Stage-2 write pipeline
  logic              s2_valid, s2_first, s2_fwd;
  logic [CH_W-1:0]   s2_ch;
  logic [ADDR_W-1:0] s2_addr;
  logic [DATA_W-1:0] s2_data;
  logic [ACC_W-1:0]  fwd_q, s2_base, s2_res;
  logic [ACC_W:0]    s2_sum;

  // Readout pipeline
  logic              ra_valid;
  logic [CH_W-1:0]   ra_ch;
  logic [DATA_W-1:0] ra_bias;
  logic signed [ACC_W:0] q_sum, q_sh;
  logic [DATA_W-1:0] q_sat, q_out;

  logic [DATA_W-1:0] bias_q [NUM_CH];
  logic [ACC_W-1:0]  acc_rd [NUM_CH];
  logic [ACC_W-1:0]  out_rd [NUM_CH];

  assign busy     = (state == CLEAR);
  assign wr_ready = (state == IDLE);
  assign clr_last = (clr_cnt == ADDR_W'(DEPTH - 1));
  assign wr_oob   = (int'(wr_ch) >= NUM_CH) || (int'(wr_addr) >= DEPTH);
  assign rd_oob   = (int'(rd_ch) >= NUM_CH) || (int'(rd_addr) >= DEPTH);
  assign wr_fire  = wr_valid && wr_ready && !wr_oob;
  assign rd_fire  = rd_req && (state == IDLE) && !rd_oob;

  // FSM state register; reset lands in CLEAR so banks start zeroed.
  always_ff @(posedge clk) begin
    if (!rst) state <= CLEAR;
    else      state <= next_state;
  end

  // FSM next state: clr_start is ignored while the sweep runs.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (clr_start) next_state = CLEAR;
      CLEAR:   if (clr_last)  next_state = IDLE;
      default: next_state = CLEAR;
    endcase
  end

  // Sweep address counter, one address of every bank per cycle.
  always_ff @(posedge clk) begin
    if (!rst || state != CLEAR || clr_last) clr_cnt <= '0;
    else                                    clr_cnt <= clr_cnt + ADDR_W'(1);
  end

  // Sticky out-of-range flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst) err_oob <= 1'b0;
    else if ((wr_valid && wr_ready && wr_oob) || (rd_req && rd_oob)) err_oob <= 1'b1;
  end

  // Stage 1 -> stage 2 register; flags a hazard with the write in stage 2.
  always_ff @(posedge clk) begin
    if (!rst) s2_valid <= 1'b0;
    else      s2_valid <= wr_fire;
    s2_ch    <= wr_ch;
    s2_addr  <= wr_addr;
    s2_data  <= wr_data;
    s2_first <= wr_first;
    s2_fwd   <= s2_valid && (s2_ch == wr_ch) && (s2_addr == wr_addr);
    fwd_q    <= s2_res;
  end

  // Stage 2: the RAM has not yet seen the previous result on a hazard,
  // so take it from the forwarding register instead.
  always_comb begin
    s2_base = s2_fwd ? fwd_q : acc_rd[s2_ch];
    s2_sum  = {s2_base[ACC_W-1], s2_base} + {{(ACC_W+1-DATA_W){s2_data[DATA_W-1]}}, s2_data};
    s2_res  = s2_first ? {{(ACC_W-DATA_W){s2_data[DATA_W-1]}}, s2_data} : sat_acc(s2_sum);
  end

  // Banks: the sweep owns the write port while busy. A stage-2 write
  // still in flight on the first sweep cycle is overwritten by the sweep.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_bank
    logic bank_we;
    assign bank_we = busy || (s2_valid && (s2_ch == CH_W'(c)));
    acc_bank_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .W(ACC_W)) u_ram (
      .clk     (clk),
      .we      (bank_we),
      .waddr   (busy ? clr_cnt : s2_addr),
      .wdata   (busy ? '0 : s2_res),
      .raddr_a (wr_addr),
      .rdata_a (acc_rd[c]),
      .raddr_b (rd_addr),
      .rdata_b (out_rd[c])
    );
  end

  // Bias registers, writable in any state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) bias_q[i] <= '0;
    end else if (bias_we && int'(bias_ch) < NUM_CH) begin
      bias_q[bias_ch] <= bias_data;
    end
  end

  // Readout stage A: capture channel and the bias as of the request cycle.
  always_ff @(posedge clk) begin
    if (!rst) ra_valid <= 1'b0;
    else      ra_valid <= rd_fire;
    ra_ch   <= rd_ch;
    ra_bias <= bias_q[rd_ch];
  end

  // Quantiser: add bias, arithmetic shift, saturate, optional ReLU.
  always_comb begin
    q_sum = {out_rd[ra_ch][ACC_W-1], out_rd[ra_ch]}
          + {{(ACC_W+1-DATA_W){ra_bias[DATA_W-1]}}, ra_bias};
    q_sh  = q_sum >>> SHIFT;
    q_sat = sat_data(q_sh);
`ifdef RESULT_ACC_RELU_EN
    q_out = q_sat[DATA_W-1] ? '0 : q_sat;
`else
    q_out = q_sat;
`endif
  end

  // Readout stage B: registered output.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= ra_valid;
      if (ra_valid) rd_data <= q_out;
    end
  end

endmodule

// File: tb/tb_result_acc_bank.sv
// Bench for result_acc_bank: reference model of the banks and biases,
// readout scoreboard with latency tracking.
module tb_result_acc_bank;

  localparam int NUM_CH = 8;
  localparam int DEPTH  = 784;
  localparam int DATA_W = 8;
  localparam int SHIFT  = 1;
  localparam int ADDR_W = 10;
  localparam int CH_W   = 3;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic              clr_start, busy, wr_valid, wr_ready, wr_first;
  logic [CH_W-1:0]   wr_ch, bias_ch, rd_ch;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [DATA_W-1:0] wr_data, bias_data, rd_data;
  logic              bias_we, rd_req, rd_valid, err_oob;

  result_acc_bank dut (
    .clk(clk), .rst(rst), .clr_start(clr_start), .busy(busy),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_ch(wr_ch), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_first(wr_first),
    .bias_we(bias_we), .bias_ch(bias_ch), .bias_data(bias_data),
    .rd_req(rd_req), .rd_ch(rd_ch), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .rd_data(rd_data), .err_oob(err_oob)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model
  int mem_m [NUM_CH][DEPTH];
  int bias_m [NUM_CH];

  // Scoreboard
  logic [DATA_W-1:0] exp_q[$];
  int                iss_q[$];

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic int model_read(input int ch, input int addr);
    int v;
    v = (mem_m[ch][addr] + bias_m[ch]) >>> SHIFT;
    v = clamp(v, -128, 127);
`ifdef RESULT_ACC_RELU_EN
    if (v < 0) v = 0;
`endif
    return v;
  endfunction

  task automatic clear_model(input bit with_bias);
    for (int c = 0; c < NUM_CH; c++) begin
      for (int a = 0; a < DEPTH; a++) mem_m[c][a] = 0;
      if (with_bias) bias_m[c] = 0;
    end
  endtask

  // Readout monitor: pops the scoreboard on every rd_valid.
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("rd_unexpected", 1, 0);
      end else begin
        logic [DATA_W-1:0] e;
        int t;
        e = exp_q.pop_front();
        t = iss_q.pop_front();
        check("rd_data", $signed(rd_data), $signed(e));
        check("rd_latency", cyc - t, 2);
      end
    end
  end

  // Driver tasks (entered and left at #1 after a rising edge)
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy !== 1'b0 && k < 2000) begin @(posedge clk); #1; k++; end
    check(tag, k, DEPTH);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clr_start = 0; wr_valid = 0; bias_we = 0; rd_req = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_err_oob", err_oob, 0);
    rst = 1'b1;
    clear_model(1);
    exp_q.delete();
    iss_q.delete();
    wait_idle("clear_cycles");
  endtask

  task automatic do_write(input int ch, input int addr, input int data, input bit first);
    int k = 0;
    wr_valid = 1; wr_ch = ch[CH_W-1:0]; wr_addr = addr[ADDR_W-1:0];
    wr_data = data[DATA_W-1:0]; wr_first = first;
    while (wr_ready !== 1'b1 && k < 2000) begin @(posedge clk); #1; k++; end
    if (wr_ready !== 1'b1) check("wr_ready_timeout", 0, 1);
    @(posedge clk); #1;
    wr_valid = 0;
    if (addr < DEPTH)
      mem_m[ch][addr] = first ? data : clamp(mem_m[ch][addr] + data, -32768, 32767);
  endtask

  task automatic set_bias(input int ch, input int d);
    bias_we = 1; bias_ch = ch[CH_W-1:0]; bias_data = d[DATA_W-1:0];
    @(posedge clk); #1;
    bias_we = 0;
    bias_m[ch] = d;
  endtask

  task automatic do_read(input int ch, input int addr, input bit expect_out);
    rd_req = 1; rd_ch = ch[CH_W-1:0]; rd_addr = addr[ADDR_W-1:0];
    if (expect_out && addr < DEPTH) begin
      exp_q.push_back(DATA_W'(model_read(ch, addr)));
      iss_q.push_back(cyc);
    end
    @(posedge clk); #1;
    rd_req = 0;
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 20) begin @(posedge clk); #1; k++; end
    check("drain", exp_q.size(), 0);
  endtask

  initial begin
    int k;
    rst = 0; clr_start = 0; wr_valid = 0; wr_first = 0; wr_ch = 0; wr_addr = 0; wr_data = 0;
    bias_we = 0; bias_ch = 0; bias_data = 0; rd_req = 0; rd_ch = 0; rd_addr = 0;
    do_reset();

    // Cleared entry reads back zero
    do_read(3, 10, 1);
    drain();

    // Overwrite then accumulate back-to-back, with bias
    do_write(0, 5, 20, 1);
    do_write(0, 5, -7, 0);
    set_bias(0, 3);
    idle(2);
    do_read(0, 5, 1);
    drain();

    // Positive saturation, then walk back down to check the clamp value
    for (int i = 0; i < 300; i++) do_write(7, 0, 127, i == 0);
    idle(2);
    do_read(7, 0, 1);
    for (int i = 0; i < 255; i++) do_write(7, 0, -128, 0);
    idle(2);
    do_read(7, 0, 1);
    // Negative saturation
    for (int i = 0; i < 300; i++) do_write(1, 1, -128, i == 0);
    idle(2);
    do_read(1, 1, 1);
    // Negative readout (ReLU dependent)
    do_write(2, 7, -50, 1);
    idle(2);
    do_read(2, 7, 1);
    drain();

    // Read on the cycle the entry is being written returns the old value
    do_write(4, 3, 10, 1);
    idle(2);
    wr_valid = 1; wr_ch = 4; wr_addr = 3; wr_data = 8'd5; wr_first = 0;
    @(posedge clk); #1;
    wr_valid = 0;
    do_read(4, 3, 1);
    mem_m[4][3] = 15;
    idle(2);
    do_read(4, 3, 1);
    drain();

    // Bias written in the same cycle as a readout: old bias used
    set_bias(5, 4);
    do_write(5, 2, 6, 1);
    idle(2);
    bias_we = 1; bias_ch = 5; bias_data = 8'hEC;
    do_read(5, 2, 1);
    bias_we = 0;
    bias_m[5] = -20;
    do_read(5, 2, 1);
    drain();

    // Random accumulate traffic over a small address window
    for (int i = 0; i < 150; i++) begin
      do_write($urandom_range(0, NUM_CH - 1), $urandom_range(0, 3),
               int'($urandom_range(0, 255)) - 128, $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(3);
    for (int c = 0; c < NUM_CH; c++)
      for (int a = 0; a < 4; a++) do_read(c, a, 1);
    drain();

    // Out-of-range read: no output, sticky error
    check("err_before_oob", err_oob, 0);
    do_read(2, DEPTH, 1);
    idle(4);
    check("err_oob_rd", err_oob, 1);
    drain();

    // Reset clears the error flag and the banks
    do_reset();
    check("err_after_reset", err_oob, 0);

    // Out-of-range write: dropped, sticky error
    do_write(0, 5, 40, 1);
    do_write(0, DEPTH, 100, 0);
    idle(3);
    check("err_oob_wr", err_oob, 1);
    do_read(0, 5, 1);
    do_read(0, DEPTH - 512, 1);
    idle(50);
    check("err_sticky", err_oob, 1);
    drain();

    // Clear mid-stream with writes pending
    set_bias(6, 9);
    for (int a = 0; a < 4; a++) do_write(6, a, 10 + a, 1);
    wr_valid = 1; wr_ch = 6; wr_addr = 9; wr_data = 8'd33; wr_first = 1; clr_start = 1;
    @(posedge clk); #1;
    clr_start = 0; wr_first = 0;
    rd_req = 1; rd_ch = 6; rd_addr = 0;
    k = 0;
    while (wr_ready !== 1'b1 && k < 2000) begin
      @(posedge clk); #1;
      rd_req = 0;
      k++;
    end
    wr_valid = 0;
    check("clr_ready_low", k, DEPTH);
    check("err_after_clear", err_oob, 1);
    clear_model(0);
    for (int a = 0; a < 4; a++) do_read(6, a, 1);
    do_read(6, 9, 1);
    do_read(0, 5, 1);
    do_read(7, 783, 1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
